signed_result_stage: RTL and testbench

Registered output stage placed directly downstream of `signed_adder` in the 8-bit ALU datapath. It accepts the adder's SIZE+1-bit signed sum and overflow flag over a valid/ready handshake. It then truncates or saturates the sum to SIZE bits and derives zero/negative/overflow flags. Results are buffered in a 2-entry queue so the adder side never loses a transfer when the consumer stalls, and an overflow event counter is kept for diagnostics.

---
 rtl/signed_result_stage.sv | 125 ++++++++++++
 tb/tb_signed_result_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/signed_result_stage.sv
// Output stage behind signed_adder: wraps or saturates the SIZE+1-bit sum to SIZE bits,
// derives flags, buffers results in a 2-entry FIFO and counts overflow events.
module signed_result_stage #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE:0]   in_result,
    input  logic            in_overflow,
    input  logic            sat_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic            out_zero,
    output logic            out_negative,
    output logic            out_overflow,
    output logic            out_saturated,
    input  logic            clr_count,
    output logic [7:0]      ovf_count
);

    typedef struct packed {
        logic [SIZE-1:0] data;
        logic            zero;
        logic            negative;
        logic            overflow;
        logic            saturated;
    } entry_t;

    localparam logic [SIZE-1:0] MAX_POS = {1'b0, {(SIZE-1){1'b1}}};
    localparam logic [SIZE-1:0] MIN_NEG = {1'b1, {(SIZE-1){1'b0}}};

    // head_reg drives the output ports directly, so they hold their value when empty
    entry_t     head_reg, head_next;
    entry_t     tail_reg, tail_next;
    entry_t     in_entry;
    logic [1:0] count_reg, count_next;
    logic [7:0] ovf_count_reg, ovf_count_next;
    logic       push;
    logic       pop;

    assign in_ready  = !rst && (count_reg < 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        in_entry = '0;
        if (sat_en && in_overflow) begin
            in_entry.data      = in_result[SIZE] ? MIN_NEG : MAX_POS;
            in_entry.saturated = 1'b1;
        end else begin
            in_entry.data      = in_result[SIZE-1:0];
            in_entry.saturated = 1'b0;
        end
        in_entry.zero     = (in_entry.data == '0);
        in_entry.negative = in_entry.data[SIZE-1];
        in_entry.overflow = in_overflow;
    end

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        case (count_reg)
            2'd0: begin
                if (push) begin
                    head_next  = in_entry;
                    count_next = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_next = in_entry;
                end else if (push) begin
                    tail_next  = in_entry;
                    count_next = 2'd2;
                end else if (pop) begin
                    count_next = 2'd0;
                end
            end
            2'd2: begin
                // in_ready is low when full, so only a pop can happen here
                if (pop) begin
                    head_next  = tail_reg;
                    count_next = 2'd1;
                end
            end
            default: count_next = 2'd0;
        endcase
    end

    always_comb begin
        ovf_count_next = ovf_count_reg;
        if (clr_count) begin
            ovf_count_next = 8'd0;
        end else if (push && in_overflow && (ovf_count_reg != 8'hFF)) begin
            ovf_count_next = ovf_count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= 2'd0;
            ovf_count_reg <= 8'd0;
        end else begin
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            count_reg     <= count_next;
            ovf_count_reg <= ovf_count_next;
        end
    end

    assign out_data      = head_reg.data;
    assign out_zero      = head_reg.zero;
    assign out_negative  = head_reg.negative;
    assign out_overflow  = head_reg.overflow;
    assign out_saturated = head_reg.saturated;
    assign ovf_count     = ovf_count_reg;

endmodule

// File: tb/tb_signed_result_stage.sv
// Bench for signed_result_stage: a queue-based reference model checked every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_signed_result_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_result;
    logic       in_overflow;
    logic       sat_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_zero;
    logic       out_negative;
    logic       out_overflow;
    logic       out_saturated;
    logic       clr_count;
    logic [7:0] ovf_count;

    int checks   = 0;
    int failures = 0;
    bit started  = 0;

    signed_result_stage #(.SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_overflow(in_overflow), .sat_en(sat_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_negative(out_negative), .out_overflow(out_overflow),
        .out_saturated(out_saturated), .clr_count(clr_count), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit zero;
        bit negative;
        bit overflow;
        bit saturated;
    } exp_t;

    exp_t mq[$];
    int   m_cnt;
    bit   m_clean;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion from arithmetic values: saturate to [-128,127] or keep low 8 bits
    function automatic exp_t convert(input logic [8:0] r, input bit ovf, input bit sat);
        exp_t e;
        int   v;
        v = (r[8]) ? (int'(r) - 512) : int'(r);
        if (sat && ovf) begin
            e.data      = (v < 0) ? 128 : 127;
            e.saturated = 1;
        end else begin
            e.data      = ((v % 256) + 256) % 256;
            e.saturated = 0;
        end
        e.zero     = (e.data == 0);
        e.negative = (e.data >= 128);
        e.overflow = ovf;
        return e;
    endfunction

    always @(posedge clk) begin
        bit acc;
        bit pop;
        if (rst) begin
            mq.delete();
            m_cnt   = 0;
            m_clean = 1;
        end else begin
            acc = in_valid && (mq.size() < 2);
            pop = (mq.size() > 0) && out_ready;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(convert(in_result, in_overflow, sat_en));
                m_clean = 0;
            end
            if (clr_count) m_cnt = 0;
            else if (acc && in_overflow) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_in_ready", in_ready, (!rst && mq.size() < 2));
            chk("m_out_valid", out_valid, (mq.size() > 0));
            chk("m_ovf_count", ovf_count, m_cnt);
            if (mq.size() > 0) begin
                chk("m_data", out_data, mq[0].data);
                chk("m_flags", {out_zero, out_negative, out_overflow, out_saturated},
                    {mq[0].zero, mq[0].negative, mq[0].overflow, mq[0].saturated});
            end else if (m_clean) begin
                chk("m_reset_outputs", {out_data, out_zero, out_negative, out_overflow, out_saturated}, 0);
            end
        end
    end

    task automatic send(input logic [8:0] r, input logic o, input logic s);
        int   n;
        logic acc;
        n = 0;
        in_valid = 1; in_result = r; in_overflow = o; sat_en = s;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #2;
            n++;
        end while (!acc && n < 50);
        if (!acc) chk("send_timeout", 0, 1);
        $display("send result=%03h ovf=%0b sat=%0b -> out_data=%02h z=%0b n=%0b o=%0b s=%0b cnt=%0d",
                 r, o, s, out_data, out_zero, out_negative, out_overflow, out_saturated, ovf_count);
        in_valid = 0;
    endtask

    task automatic head_is(input string name, input logic [7:0] d, input logic [3:0] flags);
        chk({name, "_valid"}, out_valid, 1);
        chk({name, "_data"}, out_data, d);
        chk({name, "_flags"}, {out_zero, out_negative, out_overflow, out_saturated}, flags);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_result = 0; in_overflow = 0; sat_en = 0;
        out_ready = 0; clr_count = 0;
        @(posedge clk); #1 started = 1;
        @(posedge clk); #2;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_ovf_count", ovf_count, 0);
        @(posedge clk); #2 rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #2 out_ready = 1;

        send(9'h005, 0, 1);
        head_is("basic", 8'h05, 4'b0000);
        chk("basic_cnt", ovf_count, 0);
        send(9'h080, 1, 1);
        head_is("sat_pos", 8'h7F, 4'b0011);
        chk("sat_pos_cnt", ovf_count, 1);
        send(9'h17F, 1, 1);
        head_is("sat_neg", 8'h80, 4'b0111);
        chk("sat_neg_cnt", ovf_count, 2);
        send(9'h080, 1, 0);
        head_is("wrap", 8'h80, 4'b0110);
        chk("wrap_cnt", ovf_count, 3);
        send(9'h000, 0, 0);
        head_is("zero", 8'h00, 4'b1000);

        // backpressure: A, B accepted, C held until space frees
        @(posedge clk); #2 out_ready = 0;
        in_valid = 1; in_overflow = 0; sat_en = 0; in_result = 9'h001;
        @(posedge clk); #2 in_result = 9'h002;
        @(posedge clk); #2 in_result = 9'h003;
        @(negedge clk);
        chk("bp_full_ready", in_ready, 0);
        chk("bp_head_a", out_data, 8'h01);
        @(posedge clk); #2;
        @(negedge clk);
        chk("bp_stable_a", out_data, 8'h01);
        @(posedge clk); #2 out_ready = 1;
        @(negedge clk);
        chk("bp_out_a", out_data, 8'h01);
        @(posedge clk); #2;
        @(negedge clk);
        chk("bp_out_b", out_data, 8'h02);
        chk("bp_ready_again", in_ready, 1);
        @(posedge clk); #2 in_valid = 0;
        @(negedge clk);
        chk("bp_out_c", out_data, 8'h03);
        @(posedge clk); #2;
        @(negedge clk);
        chk("bp_drained", out_valid, 0);
        $display("backpressure sequence done cnt=%0d", ovf_count);

        // overflow counter saturation and clear priority
        @(posedge clk); #2;
        in_valid = 1; in_result = 9'h080; in_overflow = 1; sat_en = 1;
        repeat (300) @(posedge clk);
        #2 chk("cnt_saturate", ovf_count, 255);
        $display("after 300 overflow transfers cnt=%0d", ovf_count);
        clr_count = 1;
        @(posedge clk); #2 clr_count = 0; in_valid = 0;
        chk("cnt_clear_priority", ovf_count, 0);
        $display("clear with overflow transfer cnt=%0d", ovf_count);

        // reset with a full queue
        @(posedge clk); #2 out_ready = 0;
        send(9'h011, 0, 0);
        send(9'h022, 0, 0);
        @(negedge clk);
        chk("full_ready", in_ready, 0);
        chk("full_valid", out_valid, 1);
        @(posedge clk); #2 rst = 1;
        @(negedge clk);
        chk("mid_rst_ready", in_ready, 0);
        @(posedge clk); #2 rst = 0;
        @(negedge clk);
        chk("after_rst_ready", in_ready, 1);
        chk("after_rst_valid", out_valid, 0);
        chk("after_rst_data", out_data, 0);
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_stale", out_valid, 0);
        end
        $display("reset flush done valid=%0b ready=%0b", out_valid, in_ready);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
